// File: rtl/morse_key_decoder.sv
// Hand-keyed Morse decoder: classifies key presses into dots/dashes by tick
// duration and emits a letter index (A=0..Z=25, 31=invalid) after a release gap.
module morse_key_decoder #(
    parameter int PRESCALE   = 1000,
    parameter int MIN_PRESS  = 2,
    parameter int DOT_MAX    = 40,
    parameter int LETTER_GAP = 80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_i,
    output logic       sym_v_o,
    output logic       sym_o,
    output logic [4:0] letter_o,
    output logic       valid_o,
    output logic       error_o,
    output logic       busy_o
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [7:0] MIN_C      = 8'(MIN_PRESS);
    localparam logic [7:0] DOT_C      = 8'(DOT_MAX);
    localparam logic [7:0] GAP_LAST_C = 8'(LETTER_GAP - 1);

    typedef enum logic [1:0] {IDLE, PRESS, GAP, EMIT} state_t;

    state_t        state_q, state_d;
    logic          key_meta_q, key_s_q, key_prev_q;
    logic [PW-1:0] presc_q;
    logic [7:0]    dur_q, dur_d;
    logic [2:0]    len_q;
    logic [3:0]    pat_q;
    logic          ovf_q;
    logic          sym_v_q, sym_q, valid_q, error_q;
    logic [4:0]    letter_q;

    logic          tick, rise, fall, gap_done;
    logic          append, dash;
    logic [4:0]    dec_letter;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_meta_q <= 1'b0;
            key_s_q    <= 1'b0;
            key_prev_q <= 1'b0;
        end else begin
            key_meta_q <= key_i;
            key_s_q    <= key_meta_q;
            key_prev_q <= key_s_q;
        end
    end

    assign rise = key_s_q & ~key_prev_q;
    assign fall = ~key_s_q & key_prev_q;
    assign tick = (presc_q == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // The gap closes on the tick that would carry dur to LETTER_GAP, so valid_o
    // lands exactly one clock after that tick.
    assign gap_done = tick && (dur_q == GAP_LAST_C);

    always_comb begin
        state_d = state_q;
        append  = 1'b0;
        dash    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) state_d = PRESS;
            end
            PRESS: begin
                if (fall) begin
                    if (dur_q < MIN_C) begin
                        state_d = (len_q == 3'd0) ? IDLE : GAP;
                    end else begin
                        append  = 1'b1;
                        dash    = (dur_q >= DOT_C);
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (rise)          state_d = PRESS;
                else if (gap_done) state_d = EMIT;
            end
            EMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dur_d = dur_q;
        if (state_d != state_q) begin
            dur_d = 8'd0;
        end else if (tick && dur_q != 8'hFF) begin
            dur_d = dur_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dur_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            dur_q   <= dur_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || state_d == IDLE) begin
            len_q <= 3'd0;
            pat_q <= 4'd0;
            ovf_q <= 1'b0;
        end else if (append) begin
            if (len_q == 3'd4) begin
                ovf_q <= 1'b1;
            end else begin
                len_q <= len_q + 3'd1;
                pat_q <= {pat_q[2:0], dash};
            end
        end
    end

    // pat is right-aligned, newest symbol in bit 0, 1 = dash
    always_comb begin
        dec_letter = 5'd31;
        case ({len_q, pat_q})
            {3'd1, 4'b0000}: dec_letter = 5'd4;   // E
            {3'd1, 4'b0001}: dec_letter = 5'd19;  // T
            {3'd2, 4'b0000}: dec_letter = 5'd8;   // I
            {3'd2, 4'b0001}: dec_letter = 5'd0;   // A
            {3'd2, 4'b0010}: dec_letter = 5'd13;  // N
            {3'd2, 4'b0011}: dec_letter = 5'd12;  // M
            {3'd3, 4'b0000}: dec_letter = 5'd18;  // S
            {3'd3, 4'b0001}: dec_letter = 5'd20;  // U
            {3'd3, 4'b0010}: dec_letter = 5'd17;  // R
            {3'd3, 4'b0011}: dec_letter = 5'd22;  // W
            {3'd3, 4'b0100}: dec_letter = 5'd3;   // D
            {3'd3, 4'b0101}: dec_letter = 5'd10;  // K
            {3'd3, 4'b0110}: dec_letter = 5'd6;   // G
            {3'd3, 4'b0111}: dec_letter = 5'd14;  // O
            {3'd4, 4'b0000}: dec_letter = 5'd7;   // H
            {3'd4, 4'b0001}: dec_letter = 5'd21;  // V
            {3'd4, 4'b0010}: dec_letter = 5'd5;   // F
            {3'd4, 4'b0100}: dec_letter = 5'd11;  // L
            {3'd4, 4'b0110}: dec_letter = 5'd15;  // P
            {3'd4, 4'b0111}: dec_letter = 5'd9;   // J
            {3'd4, 4'b1000}: dec_letter = 5'd1;   // B
            {3'd4, 4'b1001}: dec_letter = 5'd23;  // X
            {3'd4, 4'b1010}: dec_letter = 5'd2;   // C
            {3'd4, 4'b1011}: dec_letter = 5'd24;  // Y
            {3'd4, 4'b1100}: dec_letter = 5'd25;  // Z
            {3'd4, 4'b1101}: dec_letter = 5'd16;  // Q
            default:         dec_letter = 5'd31;
        endcase
        if (ovf_q) dec_letter = 5'd31;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sym_v_q  <= 1'b0;
            sym_q    <= 1'b0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            letter_q <= 5'd0;
        end else begin
            sym_v_q <= append;
            sym_q   <= append & dash;
            valid_q <= (state_d == EMIT);
            error_q <= (state_d == EMIT) && (dec_letter == 5'd31);
            if (state_d == EMIT) letter_q <= dec_letter;
        end
    end

    assign sym_v_o  = sym_v_q;
    assign sym_o    = sym_q;
    assign valid_o  = valid_q;
    assign error_o  = error_q;
    assign letter_o = letter_q;
    assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_morse_key_decoder.sv
// Randomized bench for morse_key_decoder: keys Morse strings and checks symbols
// and letters against a string-table reference model.
module tb_morse_key_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_i;
    logic       sym_v_o, sym_o, valid_o, error_o, busy_o;
    logic [4:0] letter_o;

    int checks = 0;
    int failures = 0;
    int last_letter = 0;
    bit exp_sym[$];
    int exp_let[$];
    bit prev_valid = 1'b0;
    bit prev_sym = 1'b0;

    string morse_tab[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                             "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                             "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                             "-.--", "--.."};

    morse_key_decoder #(
        .PRESCALE(4), .MIN_PRESS(1), .DOT_MAX(3), .LETTER_GAP(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_i(key_i),
        .sym_v_o(sym_v_o), .sym_o(sym_o), .letter_o(letter_o),
        .valid_o(valid_o), .error_o(error_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int decode(input string code);
        if (code.len() > 4) return 31;
        for (int i = 0; i < 26; i++) begin
            if (morse_tab[i] == code) return i;
        end
        return 31;
    endfunction

    // Output monitor: every pulse is matched against the expectation queues.
    always @(negedge clk) begin
        if (sym_v_o) begin
            chk("sym_width", int'(prev_sym), 0);
            if (exp_sym.size() == 0) chk("sym_unexpected", 1, 0);
            else chk("sym_value", int'(sym_o), int'(exp_sym.pop_front()));
        end
        if (valid_o) begin
            chk("valid_width", int'(prev_valid), 0);
            if (exp_let.size() == 0) begin
                chk("valid_unexpected", 1, 0);
            end else begin
                int e;
                e = exp_let.pop_front();
                chk("letter", int'(letter_o), e);
                chk("error_flag", int'(error_o), int'(e == 31));
                $display("letter emitted: %0d error=%0d", letter_o, error_o);
            end
        end else if (error_o) begin
            chk("error_without_valid", 1, 0);
        end
        if (prev_valid) chk("busy_after_valid", int'(busy_o), 0);
        prev_valid = valid_o;
        prev_sym   = sym_v_o;
    end

    task automatic wait_valid(input int expected);
        int cnt;
        cnt = 0;
        exp_let.push_back(expected);
        while (valid_o !== 1'b1 && cnt < 60) begin
            @(negedge clk);
            cnt++;
        end
        chk("valid_latency_window", int'(cnt >= 24 && cnt <= 27), 1);
        last_letter = expected;
        repeat ($urandom_range(3, 10)) @(negedge clk);
    endtask

    task automatic key_symbols(input string code, input bit glitch_gap);
        for (int i = 0; i < code.len(); i++) begin
            byte c;
            bit  d;
            c = code[i];
            d = (c == 8'h2d);
            exp_sym.push_back(d);
            key_i = 1'b1;
            repeat (d ? $urandom_range(13, 40) : $urandom_range(5, 8)) @(negedge clk);
            key_i = 1'b0;
            if (i < code.len() - 1) begin
                if (glitch_gap && i == 0) begin
                    repeat (5) @(negedge clk);
                    key_i = 1'b1;
                    @(negedge clk);
                    key_i = 1'b0;
                    repeat ($urandom_range(5, 10)) @(negedge clk);
                end else begin
                    repeat ($urandom_range(8, 14)) @(negedge clk);
                end
            end
        end
    endtask

    task automatic send_letter(input string code, input bit glitch_gap, input bit glitch_end);
        chk("letter_hold", int'(letter_o), last_letter);
        key_symbols(code, glitch_gap);
        if (glitch_end) begin
            repeat (6) @(negedge clk);
            key_i = 1'b1;
            @(negedge clk);
            key_i = 1'b0;
        end
        $display("sent '%s'", code);
        wait_valid(decode(code));
    endtask

    initial begin
        string code;
        rst_n = 1'b0;
        key_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_sym_v", int'(sym_v_o), 0);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_error", int'(error_o), 0);
        chk("rst_letter", int'(letter_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send_letter(".-", 1'b0, 1'b0);      // A
        send_letter("--.-", 1'b0, 1'b0);    // Q
        send_letter(".....", 1'b0, 1'b0);   // overflow
        send_letter(".-.-", 1'b0, 1'b0);    // unmapped
        send_letter(".", 1'b0, 1'b0);       // E
        send_letter(".", 1'b0, 1'b1);       // E with glitch in letter gap

        // Reset mid-letter discards the symbols already keyed
        key_symbols(".-", 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("reset_letter", int'(letter_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        $display("mid-letter reset applied");
        last_letter = 0;
        send_letter("-", 1'b0, 1'b0);       // T

        // Hold beyond dur saturation still yields a dash
        chk("letter_hold", int'(letter_o), last_letter);
        exp_sym.push_back(1'b1);
        key_i = 1'b1;
        repeat (1100) @(negedge clk);
        key_i = 1'b0;
        $display("sent long dash");
        wait_valid(19);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 9) < 7) begin
                code = morse_tab[$urandom_range(0, 25)];
            end else begin
                code = "";
                for (int j = 0; j < int'($urandom_range(1, 5)); j++) begin
                    code = {code, ($urandom_range(0, 1) != 0) ? "-" : "."};
                end
            end
            send_letter(code, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        repeat (10) @(negedge clk);
        chk("sym_queue_drained", exp_sym.size(), 0);
        chk("letter_queue_drained", exp_let.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
